myproject_sdiv_22s_9s_14_seq_1: RTL and testbench

Sequential signed integer divider: the inverse companion of the 14s×9s→22 product multiplier in the generated layer datapath. It divides a 22-bit signed dividend by a 9-bit signed divisor and returns a 14-bit signed quotient and a 9-bit signed remainder. It is used where normalisation and de-scaling stages must undo a fixed-point multiply. It is iterative (one quotient bit per cycle) to save DSPs, with a start/ready/done handshake toward the HLS-generated FSM.

---
 rtl/myproject_sdiv_pkg.sv | 26 ++
 rtl/myproject_sdiv_step.sv | 24 ++
 rtl/myproject_sdiv_22s_9s_14_seq_1.sv | 137 +++++++++++++
 tb/tb_myproject_sdiv_22s_9s_14_seq_1.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/myproject_sdiv_pkg.sv
// Shared constants and types for the sequential signed divider.
// Widths, FSM states, quotient saturation bounds and counter width.
package myproject_sdiv_pkg;

  localparam int DIN0_W = 22;
  localparam int DIN1_W = 9;
  localparam int DOUT_W = 14;
  localparam int CNT_W  = $clog2(DIN0_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX
  } state_e;

  // Signed quotient bounds, and the magnitudes that map onto them.
  localparam logic [DOUT_W-1:0] QMAX =
    {1'b0, {(DOUT_W-1){1'b1}}};
  localparam logic [DOUT_W-1:0] QMIN =
    {1'b1, {(DOUT_W-1){1'b0}}};
  localparam logic [DIN0_W-1:0] QMAX_MAG =
    DIN0_W'((1 << (DOUT_W-1)) - 1);
  localparam logic [DIN0_W-1:0] QMIN_MAG =
    DIN0_W'(1 << (DOUT_W-1));

endpackage

// File: rtl/myproject_sdiv_step.sv
// One combinational restoring-division step.
// pr_i/bit_i/dvs_i -> pr_o (new partial remainder), q_o (quotient bit).
module myproject_sdiv_step
  import myproject_sdiv_pkg::*;
(
  input  logic [DIN1_W:0]   pr_i,
  input  logic              bit_i,
  input  logic [DIN1_W-1:0] dvs_i,
  output logic [DIN1_W:0]   pr_o,
  output logic              q_o
);

  logic [DIN1_W+1:0] sh;
  logic [DIN1_W+1:0] dvs_x;

  assign sh    = {pr_i, bit_i};
  assign dvs_x = {2'b00, dvs_i};
  assign q_o   = (sh >= dvs_x);

  // Result is always below |divisor|, so it fits DIN1_W+1 bits.
  assign pr_o = q_o ? (DIN1_W+1)'(sh - dvs_x)
                    : (DIN1_W+1)'(sh);

endmodule

// File: rtl/myproject_sdiv_22s_9s_14_seq_1.sv
// Iterative signed divider, one quotient bit per cycle, 24-cycle latency.
// start/ready accept din0/din1; done pulses with dout/rem/ovf/dbz valid.
module myproject_sdiv_22s_9s_14_seq_1
  import myproject_sdiv_pkg::*;
#(
  parameter int din0_WIDTH = DIN0_W,
  parameter int din1_WIDTH = DIN1_W,
  parameter int dout_WIDTH = DOUT_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ready,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  ovf,
  output logic                  dbz
);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  // Dividend magnitude shifts out the top, quotient shifts in the bottom.
  logic [DIN0_W-1:0] dvd_q;
  logic [DIN1_W:0]   pr_q;
  logic [DIN1_W-1:0] dvs_q;
  logic              s0_q;
  logic              s1_q;
  logic              z_q;

  logic              done_q;
  logic [DOUT_W-1:0] dout_q;
  logic [DIN1_W-1:0] rem_q;
  logic              ovf_q;
  logic              dbz_q;

  logic [DIN1_W:0]   pr_d;
  logic              qb_d;
  logic [DOUT_W-1:0] dout_d;
  logic [DIN1_W-1:0] rem_d;
  logic              ovf_d;

  myproject_sdiv_step u_step (
    .pr_i  (pr_q),
    .bit_i (dvd_q[DIN0_W-1]),
    .dvs_i (dvs_q),
    .pr_o  (pr_d),
    .q_o   (qb_d)
  );

  always_comb begin
    dout_d = '0;
    ovf_d  = 1'b0;
    unique case (1'b1)
      z_q: begin
        dout_d = s0_q ? QMIN : QMAX;
      end
      (!z_q && !(s0_q ^ s1_q) && dvd_q > QMAX_MAG): begin
        dout_d = QMAX;
        ovf_d  = 1'b1;
      end
      (!z_q && (s0_q ^ s1_q) && dvd_q > QMIN_MAG): begin
        dout_d = QMIN;
        ovf_d  = 1'b1;
      end
      default: begin
        dout_d = (s0_q ^ s1_q) ? DOUT_W'(~dvd_q + 1'b1)
                               : DOUT_W'(dvd_q);
      end
    endcase
    // Remainder follows the dividend's sign; forced to 0 on zero divisor.
    rem_d = '0;
    if (!z_q)
      rem_d = s0_q ? DIN1_W'(~pr_q + 1'b1) : DIN1_W'(pr_q);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      pr_q    <= '0;
      dvs_q   <= '0;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      z_q     <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            // -2^21 negates to 2^21, exact as an unsigned 22-bit value.
            dvd_q   <= din0[DIN0_W-1] ? DIN0_W'(~din0 + 1'b1) : din0;
            dvs_q   <= din1[DIN1_W-1] ? DIN1_W'(~din1 + 1'b1) : din1;
            s0_q    <= din0[DIN0_W-1];
            s1_q    <= din1[DIN1_W-1];
            z_q     <= (din1 == '0);
            pr_q    <= '0;
            cnt_q   <= '0;
            state_q <= ITER;
          end
        end
        ITER: begin
          pr_q  <= pr_d;
          dvd_q <= {dvd_q[DIN0_W-2:0], qb_d};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DIN0_W - 1))
            state_q <= FIX;
        end
        FIX: begin
          dout_q  <= dout_d;
          rem_q   <= rem_d;
          ovf_q   <= ovf_d;
          dbz_q   <= z_q;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = done_q;
  assign dout  = dout_q;
  assign rem   = rem_q;
  assign ovf   = ovf_q;
  assign dbz   = dbz_q;

endmodule

// File: tb/tb_myproject_sdiv_22s_9s_14_seq_1.sv
// Directed and randomized checks of the sequential signed divider.
// Accept edge counts as edge 1; done is expected on edge 24.
module tb_myproject_sdiv_22s_9s_14_seq_1;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        start;
  logic [21:0] din0;
  logic [8:0]  din1;
  logic        ready;
  logic        done;
  logic [13:0] dout;
  logic [8:0]  rem;
  logic        ovf;
  logic        dbz;

  int n_asrt = 0;
  int n_fail = 0;

  myproject_sdiv_22s_9s_14_seq_1 dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .start  (start),
    .din0   (din0),
    .din1   (din1),
    .ready  (ready),
    .done   (done),
    .dout   (dout),
    .rem    (rem),
    .ovf    (ovf),
    .dbz    (dbz)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one division and return the edge number (accept=1) of done.
  task automatic run(input int a, input int b, output int lat);
    lat = 0;
    @(negedge ap_clk);
    start = 1'b1;
    din0  = 22'(a);
    din1  = 9'(b);
    @(posedge ap_clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge ap_clk);
      #1;
      if (done) begin
        lat = k + 1;
        break;
      end
    end
  endtask

  task automatic div_chk(input string tag, input int a, input int b,
                         input int eq, input int er,
                         input int eovf, input int edbz);
    int lat;
    run(a, b, lat);
    chk({tag, "/lat"}, lat, 24);
    chk({tag, "/q"},   $signed(dout), eq);
    chk({tag, "/r"},   $signed(rem), er);
    chk({tag, "/ovf"}, ovf, eovf);
    chk({tag, "/dbz"}, dbz, edbz);
  endtask

  initial begin
    int lat;
    int cnt;
    int a, b, eq, er, eo, ez, qf;
    logic [21:0] ra;
    logic [8:0]  rb;

    ap_rst = 1'b1;
    start  = 1'b0;
    din0   = '0;
    din1   = '0;
    repeat (3) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    chk("rst/ready", ready, 1);
    chk("rst/done",  done, 0);
    chk("rst/q",     $signed(dout), 0);
    chk("rst/r",     $signed(rem), 0);
    chk("rst/ovf",   ovf, 0);
    chk("rst/dbz",   dbz, 0);

    div_chk("p1000d7",  1000,  7,  142,  6, 0, 0);
    @(posedge ap_clk); #1;
    chk("done_one_cycle", done, 0);
    div_chk("m1000d7", -1000,  7, -142, -6, 0, 0);
    div_chk("p1000dm7", 1000, -7, -142,  6, 0, 0);
    div_chk("satpos",  2097151,  1,  8191, 0, 1, 0);
    div_chk("satneg", -2097152,  1, -8192, 0, 1, 0);
    div_chk("satnn",  -2097152, -1,  8191, 0, 1, 0);
    div_chk("p5d0",   5, 0,  8191, 0, 0, 1);
    div_chk("m5d0",  -5, 0, -8192, 0, 0, 1);

    // Reset aborts a division in flight after 10 iterations.
    @(negedge ap_clk);
    start = 1'b1; din0 = 22'd1000; din1 = 9'd7;
    @(posedge ap_clk);
    #1 start = 1'b0;
    repeat (10) @(posedge ap_clk);
    @(negedge ap_clk) ap_rst = 1'b1;
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    chk("abort/ready", ready, 1);
    chk("abort/done",  done, 0);
    chk("abort/q",     $signed(dout), 0);
    chk("abort/r",     $signed(rem), 0);
    chk("abort/dbz",   dbz, 0);

    // Reset wins over a simultaneous start.
    @(negedge ap_clk);
    ap_rst = 1'b1; start = 1'b1; din0 = 22'd50; din1 = 9'd5;
    @(posedge ap_clk);
    #1 ap_rst = 1'b0; start = 1'b0;
    chk("rststart/ready", ready, 1);

    div_chk("p100d3", 100, 3, 33, 1, 0, 0);

    // Back-to-back with start held high; junk offered during ITER.
    @(negedge ap_clk);
    start = 1'b1; din0 = 22'd1000; din1 = 9'd7;
    @(posedge ap_clk);
    #1 din0 = 22'(-5); din1 = 9'd3;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge ap_clk); #1;
      if (done) begin lat = k + 1; break; end
    end
    chk("b2b_a/lat", lat, 24);
    chk("b2b_a/q",   $signed(dout), 142);
    chk("b2b_a/r",   $signed(rem), 6);
    din0 = 22'd100; din1 = 9'd3;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge ap_clk); #1;
      if (k == 1) begin
        chk("b2b_b/accepted", ready, 0);
        din0 = 22'(-77); din1 = 9'd2;
      end
      if (done) begin lat = k; break; end
    end
    start = 1'b0;
    chk("b2b/spacing", lat, 24);
    chk("b2b_b/q",     $signed(dout), 33);
    chk("b2b_b/r",     $signed(rem), 1);
    cnt = 0;
    repeat (30) begin
      @(posedge ap_clk); #1;
      if (done) cnt++;
    end
    chk("b2b/no_extra", cnt, 0);
    chk("b2b/idle",     ready, 1);

    // Random operands against truncating C division with saturation.
    for (int i = 0; i < 300; i++) begin
      ra = 22'($urandom);
      rb = 9'($urandom);
      if (i % 4 == 0) rb = 9'($urandom_range(0, 6)) - 9'd3;
      if (i % 7 == 0) ra = 22'($urandom_range(0, 4000)) - 22'd2000;
      a = $signed(ra);
      b = $signed(rb);
      eo = 0; ez = 0; er = 0;
      if (b == 0) begin
        ez = 1;
        eq = (a < 0) ? -8192 : 8191;
      end else begin
        qf = a / b;
        er = a % b;
        if (qf > 8191) begin eq = 8191; eo = 1; end
        else if (qf < -8192) begin eq = -8192; eo = 1; end
        else eq = qf;
      end
      div_chk($sformatf("rnd%0d", i), a, b, eq, er, eo, ez);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
